// File: rtl/lcd_bus_ctrl_pkg.sv
// Shared types and constants for the HD44780-style LCD bus controller:
// FSM states, init command ROM and command codes.
package lcd_pkg;

   typedef enum logic [2:0] {
      PWRUP,
      LOAD,
      SETUP,
      PULSE,
      HOLD,
      WAIT,
      IDLE
   } lcd_state_t;

   localparam logic [7:0] CMD_CLEAR    = 8'h01;
   localparam logic [7:0] CMD_HOME     = 8'h02;
   localparam logic [7:0] CMD_FUNC_SET = 8'h38;
   localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
   localparam logic [7:0] CMD_ENTRY    = 8'h06;

   localparam int INIT_LEN = 6;
   localparam logic [7:0] INIT_ROM [INIT_LEN] = '{
      CMD_FUNC_SET, CMD_FUNC_SET, CMD_FUNC_SET, CMD_DISP_ON, CMD_CLEAR, CMD_ENTRY
   };

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Clear and both home encodings (0x02/0x03) need the long settle time.
   function automatic logic is_slow_cmd(input logic rs, input logic [7:0] d);
      return !rs && (d == CMD_CLEAR || d == CMD_HOME || d == (CMD_HOME | 8'h01));
   endfunction

endpackage

// File: rtl/lcd_bus_ctrl_if.sv
// Request handshake between the core's LCD MMIO register and the controller.
interface lcd_bus_ctrl_if;
   logic       req_vld;
   logic       req_rs;
   logic [7:0] req_data;
   logic       req_rdy;

   modport master (output req_vld, output req_rs, output req_data, input  req_rdy);
   modport slave  (input  req_vld, input  req_rs, input  req_data, output req_rdy);
endinterface

// File: rtl/lcd_bus_ctrl_timer.sv
// Loadable down-counter; done while the count sits at 1, so a state that
// loads N on entry and leaves on done lasts exactly N cycles.
module lcd_cycle_timer #(
   parameter int W       = 8,
   parameter int RST_VAL = 1
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   output logic         o_done
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= W'(RST_VAL);
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (r_cnt > W'(1)) begin
         r_cnt <= r_cnt - W'(1);
      end
   end

   assign o_done = (r_cnt == W'(1));

endmodule

// File: rtl/lcd_bus_ctrl.sv
// HD44780 write-only bus controller: power-up init sequence, then byte
// writes from the core with setup / enable / hold / settle timing.
module lcd_bus_ctrl
   import lcd_pkg::*;
#(
   parameter int PWRUP_CYC      = 750000,
   parameter int SETUP_CYC      = 4,
   parameter int EN_HIGH_CYC    = 12,
   parameter int HOLD_CYC       = 4,
   parameter int CMD_WAIT_CYC   = 2500,
   parameter int CLEAR_WAIT_CYC = 82000
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   lcd_bus_ctrl_if.slave req_if,
   output logic          o_lcd_on,
   output logic          o_lcd_en,
   output logic          o_lcd_rs,
   output logic          o_lcd_rw,
   output logic [7:0]    o_lcd_data,
   output logic          o_init_done
);

   localparam int MAX_CYC = max2(max2(max2(PWRUP_CYC, SETUP_CYC), max2(EN_HIGH_CYC, HOLD_CYC)),
                                 max2(CMD_WAIT_CYC, CLEAR_WAIT_CYC));
   localparam int CW = $clog2(MAX_CYC) + 1;

   generate
      if (PWRUP_CYC < 1 || SETUP_CYC < 1 || EN_HIGH_CYC < 1 || HOLD_CYC < 1 ||
          CMD_WAIT_CYC < 1 || CLEAR_WAIT_CYC < 1) begin : g_bad_param
         $fatal(1, "lcd_bus_ctrl: every timing parameter must be at least 1");
      end
   endgenerate

   lcd_state_t     r_state, w_state_next;
   logic [2:0]     r_idx, w_idx_next;
   logic           r_rs, w_rs_next;
   logic [7:0]     r_data, w_data_next;
   logic           r_init_done, w_init_done_next;
   logic           r_en, r_rdy, r_on;
   logic           w_accept, w_load, w_done;
   logic [CW-1:0]  w_load_val;

   assign w_accept = (r_state == IDLE) && r_rdy && req_if.req_vld;

   always_comb begin
      w_state_next     = r_state;
      w_idx_next       = r_idx;
      w_rs_next        = r_rs;
      w_data_next      = r_data;
      w_init_done_next = r_init_done;
      unique case (r_state)
         PWRUP: if (w_done) begin
            w_state_next = LOAD;
            w_idx_next   = 3'd0;
         end
         LOAD: begin
            w_state_next = SETUP;
            w_rs_next    = 1'b0;
            w_data_next  = INIT_ROM[r_idx];
         end
         SETUP: if (w_done) w_state_next = PULSE;
         PULSE: if (w_done) w_state_next = HOLD;
         HOLD:  if (w_done) w_state_next = WAIT;
         WAIT: if (w_done) begin
            if (r_init_done) begin
               w_state_next = IDLE;
            end else if (r_idx < 3'(INIT_LEN - 1)) begin
               w_idx_next   = r_idx + 3'd1;
               w_state_next = LOAD;
            end else begin
               w_init_done_next = 1'b1;
               w_state_next     = IDLE;
            end
         end
         IDLE: if (w_accept) begin
            w_state_next = SETUP;
            w_rs_next    = req_if.req_rs;
            w_data_next  = req_if.req_data;
         end
         default: w_state_next = PWRUP;
      endcase
   end

   // Timer reloads on every state change with the duration of the state being entered.
   always_comb begin
      w_load     = (w_state_next != r_state);
      w_load_val = CW'(1);
      unique case (w_state_next)
         PWRUP:   w_load_val = CW'(PWRUP_CYC);
         SETUP:   w_load_val = CW'(SETUP_CYC);
         PULSE:   w_load_val = CW'(EN_HIGH_CYC);
         HOLD:    w_load_val = CW'(HOLD_CYC);
         WAIT:    w_load_val = is_slow_cmd(r_rs, r_data) ? CW'(CLEAR_WAIT_CYC) : CW'(CMD_WAIT_CYC);
         default: w_load_val = CW'(1);
      endcase
   end

   lcd_cycle_timer #(.W(CW), .RST_VAL(PWRUP_CYC)) u_timer (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .o_done     (w_done)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= PWRUP;
         r_idx       <= 3'd0;
         r_rs        <= 1'b0;
         r_data      <= 8'h00;
         r_init_done <= 1'b0;
         r_en        <= 1'b0;
         r_rdy       <= 1'b0;
         r_on        <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_idx       <= w_idx_next;
         r_rs        <= w_rs_next;
         r_data      <= w_data_next;
         r_init_done <= w_init_done_next;
         r_en        <= (w_state_next == PULSE);
         r_rdy       <= (w_state_next == IDLE);
         r_on        <= 1'b1;
      end
   end

   assign req_if.req_rdy = r_rdy;
   assign o_lcd_on       = r_on;
   assign o_lcd_en       = r_en;
   assign o_lcd_rs       = r_rs;
   assign o_lcd_rw       = 1'b0;
   assign o_lcd_data     = r_data;
   assign o_init_done    = r_init_done;

endmodule
